// File: rtl/exe_if.sv
// Bundle of ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface exe_if #(
   parameter int DATA_W = 32
);
   logic              flush;
   logic [3:0]        exe_cmd;
   logic [1:0]        br_type;
   logic              is_imm;
   logic              wb_en_in;
   logic              mem_r_en_in;
   logic              mem_w_en_in;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] mem_fwd;
   logic [DATA_W-1:0] wb_fwd;
   logic [1:0]        fwd_sel1;
   logic [1:0]        fwd_sel2;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] store_data;
   logic              br_taken;
   logic [DATA_W-1:0] br_addr;
   logic              wb_en;
   logic              mem_r_en;
   logic              mem_w_en;
   logic              super_stall;

   modport master (
      output flush, exe_cmd, br_type, is_imm, wb_en_in, mem_r_en_in, mem_w_en_in,
             rdata1, rdata2, imm, pc, mem_fwd, wb_fwd, fwd_sel1, fwd_sel2,
      input  alu_result, store_data, br_taken, br_addr, wb_en, mem_r_en, mem_w_en,
             super_stall
   );

   modport slave (
      input  flush, exe_cmd, br_type, is_imm, wb_en_in, mem_r_en_in, mem_w_en_in,
             rdata1, rdata2, imm, pc, mem_fwd, wb_fwd, fwd_sel1, fwd_sel2,
      output alu_result, store_data, br_taken, br_addr, wb_en, mem_r_en, mem_w_en,
             super_stall
   );
endinterface

// File: rtl/exe_stage.sv
// Pipeline execute stage: forwarding muxes, ALU, branch resolution and an optional
// 32-cycle shift-add multiplier, built only when EXE_MUL_EN is defined.
module exe_stage #(
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic rst,
   exe_if.slave bus
);
   logic [DATA_W-1:0] reg_val [2];
   logic [1:0]        fwd_sel [2];
   logic [DATA_W-1:0] fwd_op  [2];
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2f;
   logic [DATA_W-1:0] op2;
   logic [4:0]        shamt;
   logic [DATA_W-1:0] alu_comb;
   logic              br_eval;
   logic              mul_stall;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;

   assign reg_val[0] = bus.rdata1;
   assign reg_val[1] = bus.rdata2;
   assign fwd_sel[0] = bus.fwd_sel1;
   assign fwd_sel[1] = bus.fwd_sel2;

   // Selector value 3 deliberately falls back to the register operand.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_op[gi] = (fwd_sel[gi] == 2'd1) ? bus.mem_fwd :
                          (fwd_sel[gi] == 2'd2) ? bus.wb_fwd  : reg_val[gi];
   end

   assign op1   = fwd_op[0];
   assign op2f  = fwd_op[1];
   assign op2   = bus.is_imm ? bus.imm : op2f;
   assign shamt = op2[4:0];

   always_comb begin
      alu_comb = '0;
      case (bus.exe_cmd)
         4'd0:    alu_comb = op1 + op2;
         4'd1:    alu_comb = op1 - op2;
         4'd2:    alu_comb = op1 & op2;
         4'd3:    alu_comb = op1 | op2;
         4'd4:    alu_comb = ~(op1 | op2);
         4'd5:    alu_comb = op1 ^ op2;
         4'd6:    alu_comb = op1 << shamt;
         4'd7:    alu_comb = $signed(op1) >>> shamt;
         4'd8:    alu_comb = op1 >> shamt;
         default: alu_comb = '0;
      endcase
   end

   always_comb begin
      br_eval = 1'b0;
      case (bus.br_type)
         2'd1:    br_eval = (op1 == '0);
         2'd2:    br_eval = (op1 != op2f);
         2'd3:    br_eval = 1'b1;
         default: br_eval = 1'b0;
      endcase
   end

`ifdef EXE_MUL_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

   mul_state_t        state_reg, state_next;
   logic [4:0]        cnt_reg, cnt_next;
   logic [DATA_W-1:0] mcand_reg, mcand_next;
   logic [DATA_W-1:0] mplier_reg, mplier_next;
   logic [DATA_W-1:0] prod_reg, prod_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         prod_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         prod_reg   <= prod_next;
      end
   end

   // Outputs are masked by rst so the reset cycle behaves as if already in IDLE.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      prod_next   = prod_reg;
      mul_stall   = 1'b0;
      mul_done    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.exe_cmd == 4'd9 && !bus.flush && !rst) begin
               mul_stall   = 1'b1;
               mcand_next  = op1;
               mplier_next = op2;
               prod_next   = '0;
               cnt_next    = '0;
               state_next  = BUSY;
            end
         end
         BUSY: begin
            if (bus.flush) begin
               state_next = IDLE;
            end else begin
               mul_stall   = !rst;
               prod_next   = mplier_reg[0] ? prod_reg + mcand_reg : prod_reg;
               mcand_next  = mcand_reg << 1;
               mplier_next = mplier_reg >> 1;
               cnt_next    = cnt_reg + 5'd1;
               if (cnt_reg == 5'd31)
                  state_next = DONE;
            end
         end
         DONE: begin
            mul_done   = !rst;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign mul_product = prod_reg;
`else
   assign mul_stall   = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   assign bus.super_stall = mul_stall;
   assign bus.alu_result  = mul_stall ? '0 : (mul_done ? mul_product : alu_comb);
   assign bus.store_data  = op2f;
   assign bus.br_taken    = br_eval & ~bus.flush;
   assign bus.br_addr     = bus.pc + bus.imm;
   assign bus.wb_en       = bus.wb_en_in    & ~mul_stall & ~bus.flush;
   assign bus.mem_r_en    = bus.mem_r_en_in & ~mul_stall & ~bus.flush;
   assign bus.mem_w_en    = bus.mem_w_en_in & ~mul_stall & ~bus.flush;
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter DATA_W, default 32, sets the datapath width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 flush  in  1  kills the instruction in EX and aborts any multiply in progress.
REQ-005 exe_cmd  in  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRA, 8 SRL, 9 MUL; 10-15 give a result of 0.
REQ-006 br_type  in  2  branch type: 0 none, 1 BEZ (op1==0), 2 BNE (op1!=op2), 3 JMP (always taken).
REQ-007 is_imm  in  1  when set, operand 2 of the ALU is imm.
REQ-008 wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits from ID/EX.
REQ-009 rdata1, rdata2, imm, pc, mem_fwd, wb_fwd  in  32 each  register operands, immediate, PC, and the MEM- and WB-stage forward values.
REQ-010 fwd_sel1, fwd_sel2  in  2 each  operand source: 0 register, 1 mem_fwd, 2 wb_fwd, 3 register.
REQ-011 alu_result  out  32  result of the EX stage.
REQ-012 store_data  out  32  forwarded operand 2 before the imm mux.
REQ-013 br_taken  out  1  branch resolved as taken.
REQ-014 br_addr  out  32  branch target, pc + imm.
REQ-015 wb_en, mem_r_en, mem_w_en  out  1 each  control bits passed on to EX/MEM.
REQ-016 super_stall  out  1  held high while the multiplier is busy; drives superStall on the IF, ID and ID/EX stages.

Function
REQ-017 op1 is selected by fwd_sel1; op2f is selected by fwd_sel2; op2 = is_imm ? imm : op2f; store_data = op2f.
REQ-018 The non-MUL ALU ops are combinational in 32-bit two's complement, with wrap on overflow; shifts use op2[4:0].
REQ-019 br_taken is the combinational evaluation of br_type on op1/op2f, gated to 0 by flush.
REQ-020 Multiplier FSM states are IDLE, BUSY and DONE.
REQ-021 IDLE -> BUSY when exe_cmd==9 and flush==0: op1 and op2 are latched, the counter is cleared, and super_stall=1 combinationally in that same cycle.
REQ-022 In BUSY, one shift-add step runs per cycle; after 32 BUSY cycles the FSM goes to DONE; super_stall=1 throughout BUSY.
REQ-023 In DONE, super_stall=0, alu_result is the low 32 bits of the product, and the FSM goes to IDLE on the next clock.
REQ-024 MUL latency is 34 cycles in EX: 33 cycles with super_stall=1, then 1 DONE cycle.
REQ-025 Back-to-back MULs are supported; the second MUL starts when it is seen in IDLE, the cycle after DONE.
REQ-026 A flush in BUSY or DONE returns the FSM to IDLE on the next clock; super_stall drops in the flush cycle.
REQ-027 wb_en, mem_r_en and mem_w_en are the inputs ANDed with ~super_stall and ~flush, so stall cycles send bubbles into EX/MEM.
REQ-028 While super_stall=1, alu_result=0.
REQ-029 The product is computed unsigned; the low 32 bits are equal to the signed result.

Reset
REQ-030 rst puts the FSM in IDLE and clears the counter and the operand and product registers.
REQ-031 rst overrides flush and any multiply in progress.
REQ-032 In the reset cycle all outputs follow their combinational rules with the FSM in IDLE, so super_stall=0.

Configuration
REQ-033 The macro EXE_MUL_EN controls the multiplier.
REQ-034 With EXE_MUL_EN defined, the FSM and multiplier are built as in REQ-020..029.
REQ-035 Without EXE_MUL_EN, no FSM is built, super_stall is tied to 0, and exe_cmd 9 gives alu_result=0 with control bits passed through unchanged.

Verification
REQ-036 Forwarding: rdata1=5, mem_fwd=7, fwd_sel1=1, rdata2=3, exe_cmd=0 -> alu_result=10.
REQ-037 Immediate subtract: is_imm=1, imm=0xFFFFFFFF, op1=1, exe_cmd=1 -> alu_result=2.
REQ-038 Branch: br_type=2, op1=4, op2f=4 -> br_taken=0; with op2f=5 -> br_taken=1; pc=0x100, imm=0x20 -> br_addr=0x120.
REQ-039 Multiply: MUL with op1=0x10000, op2=0x10003 -> super_stall high for 33 cycles, then DONE with alu_result=0x00030000 and wb_en=1.
REQ-040 Flush mid-multiply: flush asserted at BUSY cycle 10 -> super_stall=0 in that cycle, FSM in IDLE on the next clock, no DONE cycle, wb_en=0.
REQ-041 Reset mid-multiply, and the build without EXE_MUL_EN: rst at BUSY cycle 5 -> super_stall=0 on the next cycle; without EXE_MUL_EN, a MUL gives alu_result=0 and super_stall is never asserted.
